// File: rtl/jpeg_marker_scanner_if.sv
// Word-in / result-out bundle for jpeg_marker_scanner.
// The slave modport is the scanner's view; the master modport is the source/sink side.
interface jpeg_marker_scanner_if #(
  parameter int unsigned BYTES_PER_WORD = 4
);
  logic [8*BYTES_PER_WORD-1:0] data_in;
  logic                        data_valid;
  logic                        data_ready;
  logic                        out_ready;
  logic                        jpeg_valid;
  logic                        found_app0;
  logic                        marker_valid;
  logic [7:0]                  marker_code;
  logic [15:0]                 marker_len;
  logic                        payload_valid;
  logic [7:0]                  payload_byte;
  logic                        payload_last;
  logic                        scan_valid;
  logic [7:0]                  scan_byte;
  logic                        rst_marker_valid;
  logic [2:0]                  rst_marker_idx;
  logic                        eoi;
  logic                        error;

  modport slave (
    input  data_in, data_valid, out_ready,
    output data_ready, jpeg_valid, found_app0, marker_valid, marker_code, marker_len,
           payload_valid, payload_byte, payload_last, scan_valid, scan_byte,
           rst_marker_valid, rst_marker_idx, eoi, error
  );

  modport master (
    output data_in, data_valid, out_ready,
    input  data_ready, jpeg_valid, found_app0, marker_valid, marker_code, marker_len,
           payload_valid, payload_byte, payload_last, scan_valid, scan_byte,
           rst_marker_valid, rst_marker_idx, eoi, error
  );
endinterface

// File: rtl/jpeg_marker_scanner.sv
// JPEG marker parser: serialises big-endian words to bytes and walks SOI..EOI, reporting
// markers, forwarding segment payloads and un-stuffed entropy-coded scan bytes.
module jpeg_marker_scanner #(
  parameter int unsigned BYTES_PER_WORD = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  jpeg_marker_scanner_if.slave  s_if
);
  localparam int unsigned BPW = BYTES_PER_WORD;
  localparam int unsigned IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);

  localparam logic [3:0] S_SEEK_SOI = 4'd0;
  localparam logic [3:0] S_MRK_FF   = 4'd1;
  localparam logic [3:0] S_MRK_CODE = 4'd2;
  localparam logic [3:0] S_LEN_HI   = 4'd3;
  localparam logic [3:0] S_LEN_LO   = 4'd4;
  localparam logic [3:0] S_PAYLOAD  = 4'd5;
  localparam logic [3:0] S_SCAN     = 4'd6;
  localparam logic [3:0] S_SCAN_FF  = 4'd7;
  localparam logic [3:0] S_ERR      = 4'd8;

  // Input buffer: the current byte is always the top byte of r_word (shifted on consume).
  logic [8*BPW-1:0] r_word;
  logic [IW-1:0]    r_idx;
  logic             r_full;
  logic             r_alive;

  logic [3:0]  r_state, w_state_nxt;
  logic        r_seek_ff, w_seek_ff_nxt;
  logic [7:0]  r_code, w_code_nxt;
  logic [7:0]  r_len_hi, w_len_hi_nxt;
  logic [15:0] r_count, w_count_nxt;

  logic        r_jpeg_valid, w_jpeg_valid_nxt;
  logic        r_found_app0, w_found_app0_nxt;
  logic        r_error, w_error_nxt;
  logic        r_marker_valid, w_marker_valid_nxt;
  logic [7:0]  r_marker_code, w_marker_code_nxt;
  logic [15:0] r_marker_len, w_marker_len_nxt;
  logic        r_payload_valid, w_payload_valid_nxt;
  logic [7:0]  r_payload_byte, w_payload_byte_nxt;
  logic        r_payload_last, w_payload_last_nxt;
  logic        r_scan_valid, w_scan_valid_nxt;
  logic [7:0]  r_scan_byte, w_scan_byte_nxt;
  logic        r_rst_valid, w_rst_valid_nxt;
  logic [2:0]  r_rst_idx, w_rst_idx_nxt;
  logic        r_eoi, w_eoi_nxt;

  logic        w_last, w_consume, w_ready, w_accept;
  logic [7:0]  w_byte;
  logic [15:0] w_len;
  logic        w_code_path, w_set_err, w_is_rst;

  assign w_byte    = r_word[8*BPW-1 -: 8];
  assign w_last    = (r_idx == LAST_IDX);
  assign w_consume = r_full && s_if.out_ready;
  assign w_ready   = r_alive && ((r_state == S_ERR) || !r_full || (w_last && s_if.out_ready));
  assign w_accept  = s_if.data_valid && w_ready;
  assign w_len     = {r_len_hi, w_byte};
  assign w_is_rst  = (w_byte[7:3] == 5'b11010);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word  <= '0;
      r_idx   <= '0;
      r_full  <= 1'b0;
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      // Words accepted while in ERR are dropped; the buffer just drains.
      if (w_accept && (r_state != S_ERR)) begin
        r_word <= s_if.data_in;
        r_idx  <= '0;
        r_full <= 1'b1;
      end else if (w_consume) begin
        r_word <= r_word << 8;
        if (w_last) r_full <= 1'b0;
        else        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_seek_ff_nxt       = r_seek_ff;
    w_code_nxt          = r_code;
    w_len_hi_nxt        = r_len_hi;
    w_count_nxt         = r_count;
    w_jpeg_valid_nxt    = r_jpeg_valid;
    w_found_app0_nxt    = r_found_app0;
    w_error_nxt         = r_error;
    w_marker_valid_nxt  = 1'b0;
    w_marker_code_nxt   = r_marker_code;
    w_marker_len_nxt    = r_marker_len;
    w_payload_valid_nxt = 1'b0;
    w_payload_byte_nxt  = r_payload_byte;
    w_payload_last_nxt  = 1'b0;
    w_scan_valid_nxt    = 1'b0;
    w_scan_byte_nxt     = r_scan_byte;
    w_rst_valid_nxt     = 1'b0;
    w_rst_idx_nxt       = r_rst_idx;
    w_eoi_nxt           = 1'b0;
    w_code_path         = 1'b0;
    w_set_err           = 1'b0;

    if (w_consume) begin
      case (r_state)
        S_SEEK_SOI: begin
          if (r_seek_ff && (w_byte == 8'hD8)) begin
            w_jpeg_valid_nxt   = 1'b1;
            w_found_app0_nxt   = 1'b0;
            w_marker_valid_nxt = 1'b1;
            w_marker_code_nxt  = 8'hD8;
            w_marker_len_nxt   = 16'd0;
            w_seek_ff_nxt      = 1'b0;
            w_state_nxt        = S_MRK_FF;
          end else begin
            w_seek_ff_nxt = (w_byte == 8'hFF);
          end
        end
        S_MRK_FF: begin
          if (w_byte == 8'hFF) w_state_nxt = S_MRK_CODE;
          else                 w_set_err   = 1'b1;
        end
        S_MRK_CODE: w_code_path = 1'b1;
        S_LEN_HI: begin
          w_len_hi_nxt = w_byte;
          w_state_nxt  = S_LEN_LO;
        end
        S_LEN_LO: begin
          if (w_len < 16'd2) begin
            w_set_err = 1'b1;
          end else begin
            w_marker_valid_nxt = 1'b1;
            w_marker_code_nxt  = r_code;
            w_marker_len_nxt   = w_len;
            if (r_code == 8'hE0) w_found_app0_nxt = 1'b1;
            w_count_nxt = w_len - 16'd2;
            if (w_len == 16'd2) w_state_nxt = (r_code == 8'hDA) ? S_SCAN : S_MRK_FF;
            else                w_state_nxt = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          w_payload_valid_nxt = 1'b1;
          w_payload_byte_nxt  = w_byte;
          w_payload_last_nxt  = (r_count == 16'd1);
          w_count_nxt         = r_count - 16'd1;
          if (r_count == 16'd1) w_state_nxt = (r_code == 8'hDA) ? S_SCAN : S_MRK_FF;
        end
        S_SCAN: begin
          if (w_byte == 8'hFF) begin
            w_state_nxt = S_SCAN_FF;
          end else begin
            w_scan_valid_nxt = 1'b1;
            w_scan_byte_nxt  = w_byte;
          end
        end
        S_SCAN_FF: begin
          if (w_byte == 8'h00) begin
            w_scan_valid_nxt = 1'b1;
            w_scan_byte_nxt  = 8'hFF;
            w_state_nxt      = S_SCAN;
          end else if (w_byte == 8'hFF) begin
            w_state_nxt = S_SCAN_FF;
          end else if (w_is_rst) begin
            w_rst_valid_nxt = 1'b1;
            w_rst_idx_nxt   = w_byte[2:0];
            w_state_nxt     = S_SCAN;
          end else begin
            w_code_path = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Shared marker-code decode for MRK_CODE and a non-RST marker inside a scan.
    if (w_code_path) begin
      if (w_byte == 8'hFF) begin
        w_state_nxt = S_MRK_CODE;
      end else if ((w_byte == 8'h00) || (w_byte == 8'hD8)) begin
        w_set_err = 1'b1;
      end else if (w_byte == 8'hD9) begin
        w_marker_valid_nxt = 1'b1;
        w_marker_code_nxt  = 8'hD9;
        w_marker_len_nxt   = 16'd0;
        w_eoi_nxt          = 1'b1;
        w_jpeg_valid_nxt   = 1'b0;
        w_seek_ff_nxt      = 1'b0;
        w_state_nxt        = S_SEEK_SOI;
      end else if ((w_byte == 8'h01) || w_is_rst) begin
        w_marker_valid_nxt = 1'b1;
        w_marker_code_nxt  = w_byte;
        w_marker_len_nxt   = 16'd0;
        w_state_nxt        = S_MRK_FF;
      end else begin
        w_code_nxt  = w_byte;
        w_state_nxt = S_LEN_HI;
      end
    end

    if (w_set_err) begin
      w_state_nxt = S_ERR;
      w_error_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_SEEK_SOI;
      r_seek_ff       <= 1'b0;
      r_code          <= '0;
      r_len_hi        <= '0;
      r_count         <= '0;
      r_jpeg_valid    <= 1'b0;
      r_found_app0    <= 1'b0;
      r_error         <= 1'b0;
      r_marker_valid  <= 1'b0;
      r_marker_code   <= '0;
      r_marker_len    <= '0;
      r_payload_valid <= 1'b0;
      r_payload_byte  <= '0;
      r_payload_last  <= 1'b0;
      r_scan_valid    <= 1'b0;
      r_scan_byte     <= '0;
      r_rst_valid     <= 1'b0;
      r_rst_idx       <= '0;
      r_eoi           <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_seek_ff       <= w_seek_ff_nxt;
      r_code          <= w_code_nxt;
      r_len_hi        <= w_len_hi_nxt;
      r_count         <= w_count_nxt;
      r_jpeg_valid    <= w_jpeg_valid_nxt;
      r_found_app0    <= w_found_app0_nxt;
      r_error         <= w_error_nxt;
      r_marker_valid  <= w_marker_valid_nxt;
      r_marker_code   <= w_marker_code_nxt;
      r_marker_len    <= w_marker_len_nxt;
      r_payload_valid <= w_payload_valid_nxt;
      r_payload_byte  <= w_payload_byte_nxt;
      r_payload_last  <= w_payload_last_nxt;
      r_scan_valid    <= w_scan_valid_nxt;
      r_scan_byte     <= w_scan_byte_nxt;
      r_rst_valid     <= w_rst_valid_nxt;
      r_rst_idx       <= w_rst_idx_nxt;
      r_eoi           <= w_eoi_nxt;
    end
  end

  assign s_if.data_ready       = w_ready;
  assign s_if.jpeg_valid       = r_jpeg_valid;
  assign s_if.found_app0       = r_found_app0;
  assign s_if.marker_valid     = r_marker_valid;
  assign s_if.marker_code      = r_marker_code;
  assign s_if.marker_len       = r_marker_len;
  assign s_if.payload_valid    = r_payload_valid;
  assign s_if.payload_byte     = r_payload_byte;
  assign s_if.payload_last     = r_payload_last;
  assign s_if.scan_valid       = r_scan_valid;
  assign s_if.scan_byte        = r_scan_byte;
  assign s_if.rst_marker_valid = r_rst_valid;
  assign s_if.rst_marker_idx   = r_rst_idx;
  assign s_if.eoi              = r_eoi;
  assign s_if.error            = r_error;
endmodule

// File: tb/tb_jpeg_marker_scanner.sv
// Bench for jpeg_marker_scanner: one byte stream fed to BPW=4/1/8 instances, event logs
// compared against a hand-written table of expected marker/payload/scan/RST events.
module tb_jpeg_marker_scanner;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  in_byte;
    logic [31:0] exp_ev;
  } vec_t;

  vec_t        tv[$];
  logic [7:0]  stim [0:255];
  int          n_stim = 0;
  logic [31:0] exp_q[$];
  int          run_seq = 0;
  logic        stall = 1'b0;
  int          n_checks = 0;
  int          n_err = 0;

  function automatic logic [31:0] ev_m(logic e, logic [7:0] c, logic [15:0] l);
    return {4'h1, 3'd0, e, c, l};
  endfunction
  function automatic logic [31:0] ev_p(logic last, logic [7:0] b);
    return {4'h2, 19'd0, last, b};
  endfunction
  function automatic logic [31:0] ev_s(logic [7:0] b);
    return {4'h3, 20'd0, b};
  endfunction
  function automatic logic [31:0] ev_r(logic [2:0] i);
    return {4'h4, 25'd0, i};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_w
    localparam int unsigned BPW = (g == 0) ? 4 : ((g == 1) ? 1 : 8);
    jpeg_marker_scanner_if #(.BYTES_PER_WORD(BPW)) bus ();
    jpeg_marker_scanner #(.BYTES_PER_WORD(BPW)) u_dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .s_if   (bus)
    );
    assign bus.out_ready = (g == 0) ? !stall : 1'b1;

    logic [31:0] ev_q[$];
    logic        done;
    logic        tmo;
    logic [1:0]  app0_flags;
    logic        jv_at_eoi;
    logic [2:0]  npulse;
    assign npulse = {2'b0, bus.marker_valid} + {2'b0, bus.payload_valid} +
                    {2'b0, bus.scan_valid} + {2'b0, bus.rst_marker_valid};

    always @(negedge clk) begin
      if (!rst_n) begin
        ev_q.delete();
        app0_flags <= 2'b00;
        jv_at_eoi  <= 1'b1;
      end else if (npulse > 3'd1) begin
        ev_q.push_back(32'hDEAD_0000);
      end else if (bus.eoi && !bus.marker_valid) begin
        ev_q.push_back(32'hDEAD_0001);
      end else if (bus.marker_valid) begin
        ev_q.push_back(ev_m(bus.eoi, bus.marker_code, bus.marker_len));
        if (bus.marker_code == 8'hE0) app0_flags <= {bus.jpeg_valid, bus.found_app0};
        if (bus.eoi) jv_at_eoi <= bus.jpeg_valid;
      end else if (bus.payload_valid) begin
        ev_q.push_back(ev_p(bus.payload_last, bus.payload_byte));
      end else if (bus.scan_valid) begin
        ev_q.push_back(ev_s(bus.scan_byte));
      end else if (bus.rst_marker_valid) begin
        ev_q.push_back(ev_r(bus.rst_marker_idx));
      end
    end

    initial begin
      int   seq;
      int   ptr;
      int   stuck;
      logic rdy;
      bus.data_valid = 1'b0;
      bus.data_in    = '0;
      done = 1'b1;
      tmo  = 1'b0;
      seq  = 0;
      forever begin
        wait (run_seq != seq);
        seq   = run_seq;
        done  = 1'b0;
        ptr   = 0;
        stuck = 0;
        @(negedge clk);
        while (ptr < n_stim && stuck < 500) begin
          for (int k = 0; k < int'(BPW); k++)
            bus.data_in[8*(int'(BPW)-1-k) +: 8] = (ptr + k < n_stim) ? stim[ptr+k] : 8'h00;
          bus.data_valid = 1'b1;
          #4;
          rdy = bus.data_ready;
          @(negedge clk);
          if (rdy) ptr += int'(BPW);
          else     stuck++;
        end
        bus.data_valid = 1'b0;
        tmo  = (stuck >= 500);
        done = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic [7:0] b, input logic [31:0] e);
    vec_t v;
    v.in_byte = b;
    v.exp_ev  = e;
    tv.push_back(v);
  endtask

  task automatic apply_table();
    n_stim = tv.size();
    exp_q.delete();
    for (int i = 0; i < tv.size(); i++) begin
      stim[i] = tv[i].in_byte;
      if (tv[i].exp_ev != 32'd0) exp_q.push_back(tv[i].exp_ev);
    end
    tv.delete();
    run_seq++;
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    repeat (2) @(negedge clk);
    while (!(g_w[0].done && g_w[1].done && g_w[2].done) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("stream_done", {31'd0, g_w[0].done && g_w[1].done && g_w[2].done &&
        !g_w[0].tmo && !g_w[1].tmo && !g_w[2].tmo}, 32'd1);
    repeat (20) @(negedge clk);
  endtask

  task automatic cmp_log(input string nm, input logic [31:0] lg[$]);
    chk({nm, "_count"}, 32'(lg.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk(nm, (i < lg.size()) ? lg[i] : 32'hFFFF_FFFF, exp_q[i]);
  endtask

  task automatic cmp_all(input string tag);
    cmp_log({tag, "_bpw4"}, g_w[0].ev_q);
    cmp_log({tag, "_bpw1"}, g_w[1].ev_q);
    cmp_log({tag, "_bpw8"}, g_w[2].ev_q);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic build_main();
    logic [7:0] app0 [0:13];
    logic [7:0] sos  [0:5];
    app0 = '{8'h4A, 8'h46, 8'h49, 8'h46, 8'h00, 8'h01, 8'h01,
             8'h01, 8'h00, 8'h48, 8'h00, 8'h48, 8'h00, 8'h00};
    sos  = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h3F, 8'h00};
    add(8'hFF, 0); add(8'hD8, ev_m(1'b0, 8'hD8, 16'd0));
    add(8'hFF, 0); add(8'hE0, 0); add(8'h00, 0); add(8'h10, ev_m(1'b0, 8'hE0, 16'h0010));
    for (int i = 0; i < 14; i++) add(app0[i], ev_p(i == 13, app0[i]));
    add(8'hFF, 0); add(8'hDA, 0); add(8'h00, 0); add(8'h08, ev_m(1'b0, 8'hDA, 16'h0008));
    for (int i = 0; i < 6; i++) add(sos[i], ev_p(i == 5, sos[i]));
    add(8'hAB, ev_s(8'hAB)); add(8'hFF, 0); add(8'h00, ev_s(8'hFF)); add(8'hCD, ev_s(8'hCD));
    add(8'h12, ev_s(8'h12)); add(8'hFF, 0); add(8'hD3, ev_r(3'd3)); add(8'h34, ev_s(8'h34));
    add(8'hFF, 0); add(8'hD9, ev_m(1'b1, 8'hD9, 16'd0));
  endtask

  initial begin
    int sz;
    int cyc;
    rst_n = 1'b0;
    #12;
    chk("rst_data_ready", {31'd0, g_w[0].bus.data_ready}, 32'd0);
    chk("rst_error", {31'd0, g_w[0].bus.error}, 32'd0);
    chk("rst_jpeg_valid", {31'd0, g_w[0].bus.jpeg_valid}, 32'd0);
    chk("rst_marker_valid", {31'd0, g_w[0].bus.marker_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full image: SOI, APP0, SOS, stuffed scan with RST3, EOI
    build_main();
    apply_table();
    wait_done();
    cmp_all("main");
    chk("app0_flags", {30'd0, g_w[0].app0_flags}, 32'd3);
    chk("jv_at_eoi", {31'd0, g_w[0].jv_at_eoi}, 32'd0);
    chk("jv_after_eoi", {31'd0, g_w[0].bus.jpeg_valid}, 32'd0);

    // Same stream with a 5-cycle stall mid-payload on the BPW=4 instance
    do_reset();
    build_main();
    apply_table();
    cyc = 0;
    while (g_w[0].ev_q.size() < 10 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_reached", {31'd0, g_w[0].ev_q.size() >= 10}, 32'd1);
    @(negedge clk);
    stall = 1'b1;
    #1;
    sz = g_w[0].ev_q.size();
    for (int k = 0; k < 5; k++) begin
      chk("stall_data_ready", {31'd0, g_w[0].bus.data_ready}, 32'd0);
      @(negedge clk);
      #1;
    end
    chk("stall_no_events", 32'(g_w[0].ev_q.size()), 32'(sz));
    stall = 1'b0;
    wait_done();
    cmp_all("stall");

    // Non-FF byte where a marker is required
    do_reset();
    add(8'hFF, 0); add(8'hD8, ev_m(1'b0, 8'hD8, 16'd0)); add(8'h12, 0); add(8'h00, 0);
    apply_table();
    wait_done();
    cmp_all("err_ff");
    chk("err_ff_error4", {31'd0, g_w[0].bus.error}, 32'd1);
    chk("err_ff_error1", {31'd0, g_w[1].bus.error}, 32'd1);
    chk("err_ff_error8", {31'd0, g_w[2].bus.error}, 32'd1);
    chk("err_ff_ready", {31'd0, g_w[0].bus.data_ready}, 32'd1);
    do_reset();
    chk("err_ff_cleared", {31'd0, g_w[0].bus.error}, 32'd0);

    // Segment length below 2
    add(8'hFF, 0); add(8'hD8, ev_m(1'b0, 8'hD8, 16'd0)); add(8'hFF, 0); add(8'hDB, 0);
    add(8'h00, 0); add(8'h01, 0);
    apply_table();
    wait_done();
    cmp_all("err_len");
    chk("err_len_error4", {31'd0, g_w[0].bus.error}, 32'd1);
    chk("err_len_error8", {31'd0, g_w[2].bus.error}, 32'd1);
    chk("err_len_ready", {31'd0, g_w[0].bus.data_ready}, 32'd1);
    do_reset();
    chk("err_len_cleared", {31'd0, g_w[0].bus.error}, 32'd0);

    // Reset in the middle of an APP0 payload, then a fresh SOI/EOI
    add(8'hFF, 0); add(8'hD8, ev_m(1'b0, 8'hD8, 16'd0)); add(8'hFF, 0); add(8'hE0, 0);
    add(8'h00, 0); add(8'h10, ev_m(1'b0, 8'hE0, 16'h0010));
    add(8'h4A, ev_p(1'b0, 8'h4A)); add(8'h46, ev_p(1'b0, 8'h46));
    apply_table();
    wait_done();
    cmp_all("partial");
    chk("partial_found_app0", {31'd0, g_w[0].bus.found_app0}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_jpeg_valid", {31'd0, g_w[0].bus.jpeg_valid}, 32'd0);
    chk("midrst_found_app0", {31'd0, g_w[0].bus.found_app0}, 32'd0);
    chk("midrst_marker_code", {24'd0, g_w[0].bus.marker_code}, 32'd0);
    chk("midrst_marker_len", {16'd0, g_w[0].bus.marker_len}, 32'd0);
    chk("midrst_payload_byte", {24'd0, g_w[0].bus.payload_byte}, 32'd0);
    chk("midrst_data_ready", {31'd0, g_w[0].bus.data_ready}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    add(8'hFF, 0); add(8'hD8, ev_m(1'b0, 8'hD8, 16'd0));
    add(8'hFF, 0); add(8'hD9, ev_m(1'b1, 8'hD9, 16'd0));
    apply_table();
    wait_done();
    cmp_all("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
